// File: rtl/mux_pkg.sv
// Shared types and elaboration helpers for the pipelined lane multiplexer.
package mux_pkg;

  // Widest select the sideband channel field can carry.
  localparam int CHAN_MAX = 16;

  // Per-sample sideband travelling next to the data through the tree.
  // chan carries the full effective select; each level reads its own bit.
  typedef struct packed {
    logic                valid;
    logic                sync;
    logic [CHAN_MAX-1:0] chan;
  } side_t;

  // Lowest bit index of a lane inside a packed lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Pipeline depth: ceil(select_lines / register_every).
  function automatic int latency(input int s, input int k);
    return (s + k - 1) / k;
  endfunction

  // Lane offset of tree level lvl inside the flattened triangular bus
  // (level 0 holds n lanes, level 1 holds n/2, ... the output holds 1).
  function automatic int lvl_off(input int n, input int lvl);
    return 2 * n - 2 * (n >> lvl);
  endfunction

  // A level is registered after every k-th level and always at the end.
  function automatic int lvl_reg(input int s, input int k, input int lvl);
    return (((lvl + 1) % k) == 0 || lvl == s - 1) ? 1 : 0;
  endfunction

endpackage

// File: rtl/mux_pipe_level.sv
// One level of the select tree: M lanes in, M/2 lanes out, optionally
// registered together with its sideband.
module mux_pipe_level
  import mux_pkg::*;
#(
  parameter int M   = 2,
  parameter int W   = 2,
  parameter int LVL = 0,
  parameter int REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [M*W-1:0]   d_in,
  input  side_t            side_in,
  output logic [M/2*W-1:0] d_out,
  output side_t            side_out
);

  logic [M/2*W-1:0] mux_d;

  // Pair lanes 2j/2j+1 and pick one with this level's select bit.
  genvar gi;
  for (gi = 0; gi < M / 2; gi++) begin : g_mux
    assign mux_d[lane_lo(gi, W) +: W] = side_in.chan[LVL] ?
                                        d_in[lane_lo(2 * gi + 1, W) +: W] :
                                        d_in[lane_lo(2 * gi, W) +: W];
  end

  if (REG != 0) begin : g_reg
    logic [M/2*W-1:0] d_reg;
    side_t            side_reg;

    // Stage register: cleared by reset, frozen while en is low.
    always_ff @(posedge clk) begin
      if (rst) begin
        d_reg    <= '0;
        side_reg <= '0;
      end else if (en) begin
        d_reg    <= mux_d;
        side_reg <= side_in;
      end
    end

    assign d_out    = d_reg;
    assign side_out = side_reg;
  end else begin : g_comb
    assign d_out    = mux_d;
    assign side_out = side_in;
  end

endmodule

// File: rtl/mux_pipe.sv
// Pipelined 2**SELECT_LINES : 1 lane multiplexer with valid/enable flow
// control and an auto-scan counter for time-division channel readout.
module mux_pipe
  import mux_pkg::*;
#(
  parameter int SELECT_LINES   = 4,
  parameter int DATA_WIDTH     = 2,
  parameter int REGISTER_EVERY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                valid_in,
  input  logic [SELECT_LINES-1:0]             select,
  input  logic [DATA_WIDTH*(2**SELECT_LINES)-1:0] data_in,
  input  logic                                scan_en,
  input  logic [SELECT_LINES-1:0]             scan_last,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                valid_out,
  output logic [SELECT_LINES-1:0]             chan_out,
  output logic                                sync_out
);

  localparam int N       = 2 ** SELECT_LINES;
  localparam int LATENCY = latency(SELECT_LINES, REGISTER_EVERY);

  if (REGISTER_EVERY < 1 || REGISTER_EVERY > SELECT_LINES ||
      SELECT_LINES > CHAN_MAX || LATENCY < 1) begin : g_param_check
    $error("mux_pipe: unsupported parameter combination");
  end

  logic [SELECT_LINES-1:0]          scan_cnt_reg;
  logic [SELECT_LINES-1:0]          scan_cnt_next;
  logic [SELECT_LINES-1:0]          eff_sel;
  // All tree levels packed back to back: N, N/2, ..., 1 lanes.
  logic [(2*N-1)*DATA_WIDTH-1:0]    tree;
  side_t                            side [SELECT_LINES+1];
  logic                             unused_chan_hi;

  assign eff_sel = scan_en ? scan_cnt_reg : select;

  assign tree[N*DATA_WIDTH-1:0] = data_in;
  assign side[0] = '{valid: valid_in,
                     sync:  valid_in & scan_en & (eff_sel == scan_last),
                     chan:  CHAN_MAX'(eff_sel)};

  // Next scan channel: walk 0..scan_last, wrap past the end, park at 0
  // whenever scan mode is off so each sweep begins on channel 0.
  always_comb begin
    scan_cnt_next = scan_cnt_reg;
    if (!scan_en) begin
      scan_cnt_next = '0;
    end else if (valid_in) begin
      if (scan_cnt_reg >= scan_last) begin
        scan_cnt_next = '0;
      end else begin
        scan_cnt_next = scan_cnt_reg + SELECT_LINES'(1);
      end
    end
  end

  // Scan counter register, advancing only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg <= '0;
    end else if (en) begin
      scan_cnt_reg <= scan_cnt_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < SELECT_LINES; gi++) begin : g_level
    mux_pipe_level #(
      .M   (N >> gi),
      .W   (DATA_WIDTH),
      .LVL (gi),
      .REG (lvl_reg(SELECT_LINES, REGISTER_EVERY, gi))
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .d_in     (tree[lvl_off(N, gi) * DATA_WIDTH +: (N >> gi) * DATA_WIDTH]),
      .side_in  (side[gi]),
      .d_out    (tree[lvl_off(N, gi + 1) * DATA_WIDTH +: (N >> (gi + 1)) * DATA_WIDTH]),
      .side_out (side[gi+1])
    );
  end

  assign data_out       = tree[lvl_off(N, SELECT_LINES) * DATA_WIDTH +: DATA_WIDTH];
  assign valid_out      = side[SELECT_LINES].valid;
  assign chan_out       = side[SELECT_LINES].chan[SELECT_LINES-1:0];
  assign sync_out       = side[SELECT_LINES].sync & side[SELECT_LINES].valid;
  assign unused_chan_hi = ^side[SELECT_LINES].chan;

endmodule

// File: tb/tb_mux_pipe.sv
// Self-checking bench for mux_pipe: default instance plus an S=3/W=4/k=2
// instance, both tracked by a delay-queue reference model.
module tb_mux_pipe;
  import mux_pkg::*;

  localparam int SA = 4, WA = 2, KA = 1;
  localparam int SB = 3, WB = 4, KB = 2;
  localparam int LAT_A = latency(SA, KA);
  localparam int LAT_B = latency(SB, KB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid_in = 1'b0;
  logic        scan_en = 1'b0;
  logic [3:0]  select = '0;
  logic [3:0]  scan_last = '0;
  logic [31:0] data_a = 32'h0000_0155;
  logic [31:0] data_b = '0;

  logic [1:0]  dout_a;
  logic        vout_a, sync_a;
  logic [3:0]  chan_a;
  logic [3:0]  dout_b;
  logic        vout_b, sync_b;
  logic [2:0]  chan_b;

  always #5 clk = ~clk;

  mux_pipe #(.SELECT_LINES(SA), .DATA_WIDTH(WA), .REGISTER_EVERY(KA)) dut_a (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .select(select),
    .data_in(data_a), .scan_en(scan_en), .scan_last(scan_last),
    .data_out(dout_a), .valid_out(vout_a), .chan_out(chan_a), .sync_out(sync_a));

  mux_pipe #(.SELECT_LINES(SB), .DATA_WIDTH(WB), .REGISTER_EVERY(KB)) dut_b (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .select(select[2:0]),
    .data_in(data_b), .scan_en(scan_en), .scan_last(scan_last[2:0]),
    .data_out(dout_b), .valid_out(vout_b), .chan_out(chan_b), .sync_out(sync_b));

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    bit s;
    bit rz;   // reset content: every output field must read 0
    int ch;
    int d;
  } smp_t;

  smp_t qa[$];
  smp_t qb[$];
  smp_t ea, eb;
  int   sca = 0, scb = 0;
  int   total = 0, bad = 0;
  bit   chk_on = 1'b0;

  function automatic smp_t zero_smp();
    smp_t z;
    z.v = 1'b0; z.s = 1'b0; z.rz = 1'b1; z.ch = 0; z.d = 0;
    return z;
  endfunction

  function automatic int lane(input logic [31:0] d, input int sel, input int w);
    return int'((d >> (sel * w)) & ((32'd1 << w) - 32'd1));
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    smp_t na, nb;
    int   a_sel, b_sel, b_last;
    if (rst) begin
      qa.delete(); qb.delete();
      repeat (LAT_A - 1) qa.push_back(zero_smp());
      repeat (LAT_B - 1) qb.push_back(zero_smp());
      ea = zero_smp(); eb = zero_smp();
      sca = 0; scb = 0;
      return;
    end
    if (!en) return;
    b_last = int'(scan_last[2:0]);
    a_sel = scan_en ? sca : int'(select);
    b_sel = scan_en ? scb : int'(select[2:0]);
    na.v = valid_in; na.rz = 1'b0; na.ch = a_sel; na.d = lane(data_a, a_sel, WA);
    na.s = valid_in && scan_en && (a_sel == int'(scan_last));
    nb.v = valid_in; nb.rz = 1'b0; nb.ch = b_sel; nb.d = lane(data_b, b_sel, WB);
    nb.s = valid_in && scan_en && (b_sel == b_last);
    qa.push_back(na); ea = qa.pop_front();
    qb.push_back(nb); eb = qb.pop_front();
    if (!scan_en) begin
      sca = 0; scb = 0;
    end else if (valid_in) begin
      sca = (sca >= int'(scan_last)) ? 0 : sca + 1;
      scb = (scb >= b_last) ? 0 : scb + 1;
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every cycle.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      cmp("a_valid", {31'd0, vout_a}, ea.v);
      cmp("a_sync", {31'd0, sync_a}, ea.s);
      if (ea.v || ea.rz) begin
        cmp("a_data", {30'd0, dout_a}, ea.d);
        cmp("a_chan", {28'd0, chan_a}, ea.ch);
      end
      cmp("b_valid", {31'd0, vout_b}, eb.v);
      cmp("b_sync", {31'd0, sync_b}, eb.s);
      if (eb.v || eb.rz) begin
        cmp("b_data", {28'd0, dout_b}, eb.d);
        cmp("b_chan", {29'd0, chan_b}, eb.ch);
      end
    end
  end

  // One clock: drive inputs, let the edge happen, update model, settle.
  task automatic cyc(input bit e, input bit v, input bit sc, input int sel);
    en = e; valid_in = v; scan_en = sc; select = 4'(sel);
    data_b = $urandom;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit en_pat [7];
    bit bub_pat [4];
    int n;
    en_pat  = '{1, 0, 1, 1, 0, 1, 1};
    bub_pat = '{1, 0, 0, 1};

    // Reset while en is low must still clear everything.
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    cmp("rst_valid", {31'd0, vout_a}, 0);
    cmp("rst_data", {30'd0, dout_a}, 0);
    cmp("rst_chan", {28'd0, chan_a}, 0);
    cmp("rst_sync", {31'd0, sync_a}, 0);

    // Manual sweep of all 16 channels, then three bubbles to drain.
    for (int c = 0; c < 19; c++) begin
      cyc(1, c < 16, 0, c % 16);
      if (c >= 3) begin
        cmp("sweep_valid", {31'd0, vout_a}, 1);
        cmp("sweep_chan", {28'd0, chan_a}, c - 3);
        cmp("sweep_data", {30'd0, dout_a}, (c - 3 < 5) ? 1 : 0);
      end else begin
        cmp("sweep_fill", {31'd0, vout_a}, 0);
      end
    end

    // Stall: fill with bubbles, then toggle en while feeding channel 2.
    repeat (4) cyc(1, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(en_pat[i], 1, 0, 2);
      n += int'(en_pat[i]);
      cmp("stall_valid", {31'd0, vout_a}, (n >= 4) ? 1 : 0);
      if (n >= 4) cmp("stall_data", {30'd0, dout_a}, 1);
    end

    // Scan with wrap at channel 5.
    scan_last = 4'd5;
    for (int c = 0; c < 14; c++) begin
      cyc(1, 1, 1, 0);
      if (c >= 3) begin
        cmp("scan_chan", {28'd0, chan_a}, (c - 3) % 6);
        cmp("scan_sync", {31'd0, sync_a}, ((c - 3) % 6 == 5) ? 1 : 0);
        cmp("scan_data", {30'd0, dout_a}, ((c - 3) % 6 < 5) ? 1 : 0);
      end
    end

    // Leaving scan mode for one sample (manual channel 9) clears the counter.
    cyc(1, 1, 0, 9);

    // Bubbles in scan mode: counter advances only on valid samples.
    for (int c = 0; c < 7; c++) begin
      cyc(1, (c < 4) ? bub_pat[c] : 1'b0, 1, 0);
      if (c >= 3) begin
        cmp("bubble_valid", {31'd0, vout_a}, bub_pat[c-3]);
        if (c == 3) cmp("bubble_chan0", {28'd0, chan_a}, 0);
        if (c == 6) cmp("bubble_chan1", {28'd0, chan_a}, 1);
      end
    end

    // scan_last lowered below the current count mid-sweep.
    scan_last = 4'd15;
    repeat (5) cyc(1, 1, 1, 0);
    scan_last = 4'd3;
    repeat (8) cyc(1, 1, 1, 0);

    // scan_last = 0: channel 0 repeats, every valid sample is sync.
    cyc(1, 0, 0, 0);
    scan_last = 4'd0;
    for (int c = 0; c < 6; c++) begin
      cyc(1, 1, 1, 0);
      if (c >= 3) begin
        cmp("last0_chan", {28'd0, chan_a}, 0);
        cmp("last0_sync", {31'd0, sync_a}, 1);
      end
    end

    // Reset with three scan samples in flight.
    cyc(1, 0, 0, 0);
    scan_last = 4'd5;
    repeat (3) cyc(1, 1, 1, 0);
    rst = 1'b1;
    cyc(1, 1, 1, 0);
    rst = 1'b0;
    cmp("mrst_valid", {31'd0, vout_a}, 0);
    cmp("mrst_data", {30'd0, dout_a}, 0);
    cmp("mrst_chan", {28'd0, chan_a}, 0);
    cmp("mrst_sync", {31'd0, sync_a}, 0);
    for (int c = 0; c < 4; c++) begin
      cyc(1, 1, 1, 0);
      cmp("mrst_after_valid", {31'd0, vout_a}, (c == 3) ? 1 : 0);
      if (c == 3) cmp("mrst_restart_chan", {28'd0, chan_a}, 0);
    end

    // Second instance: manual sweep of its 8 channels with random data.
    for (int c = 0; c < 10; c++) begin
      cyc(1, c < 8, 0, c % 8);
      if (c >= 1 && c <= 8) cmp("b_sweep_chan", {29'd0, chan_b}, c - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised, pipelined successor to the combinational `mux` primitive.
- Selects one DATA_WIDTH lane from 2**SELECT_LINES packed lanes through a 2:1 tree, with a configurable register density and valid/enable flow control.
- Adds an auto-scan mode: an internal counter walks the channels for time-division readout, e.g. feeding a single-lane snapshot or debug port from a multi-channel DSP bus.

Parameters:
- SELECT_LINES, 4: number of select bits; lanes N = 2**SELECT_LINES.
- DATA_WIDTH, 2: bits per lane.
- REGISTER_EVERY, 1: register after every k-th tree level (1..SELECT_LINES); final level is always registered.
- LATENCY (localparam): ceil(SELECT_LINES/REGISTER_EVERY) cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance; 0 freezes every register, including the scan counter.
- valid_in  in  1  data_in/select qualify this cycle.
- select  in  SELECT_LINES  lane index, used when scan_en=0.
- data_in  in  DATA_WIDTH*N  packed lanes; lane k = data_in[k*DATA_WIDTH +: DATA_WIDTH].
- scan_en  in  1  1 = internal counter drives the select.
- scan_last  in  SELECT_LINES  highest channel visited in scan mode.
- data_out  out  DATA_WIDTH  selected lane.
- valid_out  out  1  data_out qualifier.
- chan_out  out  SELECT_LINES  effective select that produced data_out.
- sync_out  out  1  marks the last channel of a scan sweep.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of en):
  - data_out, valid_out, chan_out, sync_out, the scan counter and all pipeline valid bits go to 0.
  - In-flight samples are discarded. The first valid_out after reset comes no earlier than LATENCY enabled cycles after the first accepted sample.
- Effective select: eff_sel = scan_en ? scan_cnt : select, sampled in the same cycle as data_in.
- Tree:
  - Level i (i=0 first) consumes eff_sel bit i.
  - Unconsumed select bits, eff_sel, the valid bit and the sync flag ride the pipeline alongside the data, so each output sample is self-consistent.
- Latency and flow:
  - A sample accepted with en=1 appears on the outputs after exactly LATENCY cycles in which en=1.
  - Cycles with en=0 hold all outputs unchanged.
  - valid_in=0 samples propagate as bubbles: valid_out=0 and data_out don't-care. There is no backpressure.
- Scan counter:
  - Increments on every cycle with en=1, valid_in=1 and scan_en=1.
  - When scan_cnt==scan_last, the next increment wraps to 0.
  - If scan_cnt>scan_last (scan_last lowered mid-sweep), the next increment wraps to 0.
  - scan_en=0 forces scan_cnt to 0 on the next enabled edge, so every sweep starts at channel 0.
- sync flag: set for an accepted sample when scan_en=1 and eff_sel==scan_last. sync_out = flag AND valid_out.
- Simultaneous events:
  - rst dominates en and valid_in.
  - scan_en dropping in the same cycle as an increment: the sample uses the old scan_cnt, then the counter clears.
- Boundaries:
  - scan_last=0: channel 0 is repeated and every valid sample is sync.
  - scan_last=N-1: full sweep.
  - SELECT_LINES=1: single level, LATENCY=1.

Decomposition:
- Package mux_pkg:
  - lane-slice helper function;
  - latency function ceil(S/k), used by both RTL and bench;
  - sideband struct typedef {valid, sync, chan}.
- Sub-module mux_pipe_level: one tree level of 2:1 muxes over M lanes, with a parameter REG (0/1) and its sideband register.
- mux_pipe instantiates SELECT_LINES levels in a generate loop and contains the scan counter.

Test Plan:
All scenarios use defaults (S=4, W=2, k=1, LATENCY=4) and data_in=32'h00000155, so lanes 0-4=2'b01 and lanes 5-15=2'b00.
- Manual sweep: scan_en=0, en=1, valid_in=1, select counting 0..15 one per cycle -> from cycle 4, data_out = 01,01,01,01,01 then 00 x11; chan_out = 0..15; valid_out=1 from cycle 4.
- Stall: en toggled 1,0,1,1,0,1,1 with select=2 -> valid_out rises after the 4th en=1 cycle; outputs frozen on every en=0 cycle.
- Scan wrap: scan_en=1, scan_last=5, continuous valid -> chan_out sequence 0,1,2,3,4,5,0,1...; sync_out=1 only with chan_out=5; data_out=01 for chans 0-4, 00 for chan 5.
- Bubbles: valid_in pattern 1,0,0,1 in scan mode -> scan_cnt advances only twice; valid_out pattern 1,0,0,1 after 4 cycles with chan_out 0,-,-,1.
- Mid-operation reset: rst=1 for one cycle while 3 samples are in flight -> next edge shows all outputs 0; no stale valid_out appears; a scan restarts at channel 0.
- Param sweep: rerun the manual sweep with S=3, W=4, k=2 (LATENCY=2) against a behavioural reference model, all 8 channels with random data.
